softmax_sequencer: RTL and testbench



---
 rtl/softmax_sequencer_pkg.sv | 33 +++
 rtl/softmax_sequencer_if.sv | 27 ++
 rtl/softmax_sequencer_divider.sv | 72 +++++++
 rtl/softmax_sequencer.sv | 152 +++++++++++++++
 tb/tb_softmax_sequencer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/softmax_sequencer_pkg.sv
// Shared types and width helpers for the classifier softmax stage.
// Every width is derived from the logit size and the Q-format shift S.
package softmax_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int IDX_W       = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        LOAD,
        EXP,
        DIV,
        OUT
    } sm_state_t;

    function automatic int data_width(input int layer2_bits);
        return layer2_bits + 25;
    endfunction

    function automatic int sum_width(input int s);
        return s + 5;
    endfunction

    function automatic int quo_width(input int s);
        return s + 1;
    endfunction

    // Numerator e_k * 2^S: e_k takes S+1 bits, then S zero bits are appended.
    function automatic int num_width(input int s);
        return 2 * s + 1;
    endfunction

endpackage

// File: rtl/softmax_sequencer_if.sv
// Logit input stream and softmax result stream of the classifier output stage.
interface softmax_sequencer_if
    import softmax_pkg::*;
#(
    parameter int W = 86
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [IDX_W-1:0] out_index;
    logic             out_last;
    logic [IDX_W-1:0] argmax;
    logic             busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last, argmax, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last, argmax, busy
    );
endinterface

// File: rtl/softmax_sequencer_divider.sv
// Unsigned restoring divider that produces one quotient bit per cycle.
// The caller guarantees num >> QUO_W < den, so the quotient fits in QUO_W bits.
module seq_divider #(
    parameter int NUM_W = 17,
    parameter int DEN_W = 13,
    parameter int QUO_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             done,
    output logic [QUO_W-1:0] quo
);
    localparam int CNT_W = $clog2(QUO_W + 1);

    logic [DEN_W-1:0] rem;
    logic [DEN_W-1:0] den_r;
    logic [QUO_W-1:0] low;
    logic [CNT_W-1:0] count;
    logic             running;

    logic [DEN_W-1:0] cur_rem;
    logic [DEN_W-1:0] cur_den;
    logic             cur_bit;
    logic [DEN_W:0]   trial;
    logic             take;
    logic [DEN_W-1:0] nxt_rem;

    // The start cycle already retires the top quotient bit, so the result is
    // complete QUO_W-1 cycles after start.
    always_comb begin
        cur_rem = start ? DEN_W'(num >> QUO_W) : rem;
        cur_den = start ? den : den_r;
        cur_bit = start ? num[QUO_W-1] : low[QUO_W-1];
        trial   = {cur_rem, cur_bit};
        take    = (trial >= {1'b0, cur_den});
        nxt_rem = take ? DEN_W'(trial - {1'b0, cur_den}) : trial[DEN_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem     <= '0;
            den_r   <= '0;
            low     <= '0;
            quo     <= '0;
            count   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem     <= nxt_rem;
                den_r   <= den;
                low     <= num[QUO_W-1:0] << 1;
                quo     <= QUO_W'(take);
                count   <= CNT_W'(QUO_W - 1);
                running <= 1'b1;
            end else if (running) begin
                rem   <= nxt_rem;
                low   <= low << 1;
                quo   <= {quo[QUO_W-2:0], take};
                count <= count - 1'b1;
                if (count == CNT_W'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/softmax_sequencer.sv
// Buffers ten logits, forms clamped linear exponents and their sum, then
// streams e_k / sum for every class through one shared iterative divider.
module softmax_sequencer
    import softmax_pkg::*;
#(
    parameter int LAYER2_BITS       = 61,
    parameter int FIXED_POINT_SHIFT = 61
) (
    input logic                clk,
    input logic                rst,
    softmax_sequencer_if.slave bus
);
    localparam int S     = FIXED_POINT_SHIFT;
    localparam int W     = data_width(LAYER2_BITS);
    localparam int SUM_W = sum_width(S);
    localparam int QUO_W = quo_width(S);
    localparam int NUM_W = num_width(S);
    localparam logic [W+1:0] ONE = (W + 2)'(1) << S;

    sm_state_t state, state_next;

    logic signed [W-1:0] buffer [NUM_CLASSES];
    logic [IDX_W-1:0]    cnt;
    logic [IDX_W-1:0]    k;
    logic signed [W-1:0] max_val;
    logic [IDX_W-1:0]    argmax_r;
    logic [SUM_W-1:0]    sum;
    logic                div_launch;
    logic                out_valid_r;
    logic [W-1:0]        out_data_r;
    logic [IDX_W-1:0]    out_index_r;
    logic                out_last_r;

    logic                in_fire;
    logic                out_fire;
    logic signed [W:0]   diff;
    logic [W+1:0]        exp_full;
    logic [S:0]          e_val;
    logic [IDX_W-1:0]    div_idx;
    logic                div_start;
    logic                div_done;
    logic [QUO_W-1:0]    div_quo;

    // Exponent of the class under cnt; the wide subtraction cannot wrap.
    always_comb begin
        in_fire   = bus.in_valid && (state == LOAD);
        out_fire  = bus.out_ready && (state == OUT);
        diff      = {buffer[cnt][W-1], buffer[cnt]} - {max_val[W-1], max_val};
        exp_full  = {diff[W], diff} + ONE;
        e_val     = exp_full[W+1] ? '0 : exp_full[S:0];
        div_idx   = (state == OUT && k != LAST_IDX) ? k + 1'b1 : k;
        div_start = div_launch || (out_fire && k != LAST_IDX);
    end

    seq_divider #(
        .NUM_W(NUM_W),
        .DEN_W(SUM_W),
        .QUO_W(QUO_W)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .start(div_start),
        .num  ({buffer[div_idx][S:0], {S{1'b0}}}),
        .den  (sum),
        .done (div_done),
        .quo  (div_quo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD: if (in_fire && cnt == LAST_IDX) state_next = EXP;
            EXP:  if (cnt == LAST_IDX) state_next = DIV;
            DIV:  if (div_done) state_next = OUT;
            OUT:  if (out_fire) state_next = (k == LAST_IDX) ? LOAD : DIV;
            default: state_next = LOAD;
        endcase
    end

    // Logits land here during LOAD and are overwritten by their exponents in EXP.
    always_ff @(posedge clk) begin
        if (in_fire)
            buffer[cnt] <= bus.in_data;
        else if (state == EXP)
            buffer[cnt] <= W'(e_val);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            k           <= '0;
            max_val     <= '0;
            argmax_r    <= '0;
            sum         <= '0;
            div_launch  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_index_r <= '0;
            out_last_r  <= 1'b0;
        end else begin
            div_launch <= 1'b0;
            case (state)
                LOAD: if (in_fire) begin
                    cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
                    if (cnt == '0 || $signed(bus.in_data) > max_val) begin
                        max_val  <= $signed(bus.in_data);
                        argmax_r <= cnt;
                    end
                end
                EXP: begin
                    sum <= sum + SUM_W'(e_val);
                    cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        div_launch <= 1'b1;
                        k          <= '0;
                    end
                end
                DIV: if (div_done) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= W'(div_quo);
                    out_index_r <= k;
                    out_last_r  <= (k == LAST_IDX);
                end
                OUT: if (out_fire) begin
                    out_valid_r <= 1'b0;
                    if (k == LAST_IDX) begin
                        max_val <= '0;
                        sum     <= '0;
                        cnt     <= '0;
                        k       <= '0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == LOAD);
    assign bus.busy      = (state != LOAD);
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_index = out_index_r;
    assign bus.out_last  = out_last_r;
    assign bus.argmax    = argmax_r;
endmodule

// File: tb/tb_softmax_sequencer.sv
// Directed frames against a plain-arithmetic softmax model, with a scoreboard
// checked on every valid output cycle plus hand-computed pins.
module tb_softmax_sequencer;
    import softmax_pkg::*;

    localparam int L2 = 8;
    localparam int S  = 8;
    localparam int W  = L2 + 25;

    typedef longint vec_t [NUM_CLASSES];
    typedef struct {
        longint data;
        int     index;
        bit     last;
        int     amax;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    softmax_sequencer_if #(.W(W)) bus ();

    softmax_sequencer #(
        .LAYER2_BITS(L2),
        .FIXED_POINT_SHIFT(S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    int    beats_seen = 0;
    beat_t exp_q[$];

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Softmax by the arithmetic rules: ties keep the lowest index, negative exponents clamp to 0.
    function automatic void softmaxModel(input vec_t lg, output vec_t q, output int amax);
        longint mx;
        longint e [NUM_CLASSES];
        longint total;
        mx    = lg[0];
        amax  = 0;
        total = 0;
        for (int i = 1; i < NUM_CLASSES; i++)
            if (lg[i] > mx) begin
                mx   = lg[i];
                amax = i;
            end
        for (int i = 0; i < NUM_CLASSES; i++) begin
            e[i] = (longint'(1) << S) + lg[i] - mx;
            if (e[i] < 0) e[i] = 0;
            total += e[i];
        end
        for (int i = 0; i < NUM_CLASSES; i++)
            q[i] = (e[i] << S) / total;
    endfunction

    task automatic applyStimulus(input vec_t lg);
        vec_t q;
        int   amax;
        int   guard;
        softmaxModel(lg, q, amax);
        for (int i = 0; i < NUM_CLASSES; i++)
            exp_q.push_back('{q[i], i, (i == NUM_CLASSES - 1), amax});
        for (int i = 0; i < NUM_CLASSES; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'(lg[i]);
            guard = 0;
            while (!bus.in_ready && guard < 1000) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 1000) begin
                checks++; failures++;
                $display("[TB] FAIL load_timeout: got in_ready=0 required 1");
                break;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic waitDrain(input string name);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 3000) begin
            checks++; failures++;
            $display("[TB] FAIL %s_drain_timeout: got %0d beats pending required 0", name, exp_q.size());
        end
    endtask

    task automatic waitBeat(input int idx);
        int guard;
        guard = 0;
        while (!(bus.out_valid && bus.out_index == IDX_W'(idx)) && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 2000) begin
            checks++; failures++;
            $display("[TB] FAIL beat%0d_timeout: got no beat required one", idx);
        end
    endtask

    // Scoreboard compare on every cycle a beat is presented.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("[TB] FAIL beat_unexpected: got out_valid=1 required 0");
            end else begin
                checkOutput("beat_data", longint'(bus.out_data), exp_q[0].data);
                checkOutput("beat_index", longint'(bus.out_index), longint'(exp_q[0].index));
                checkOutput("beat_last", longint'(bus.out_last), longint'(exp_q[0].last));
                checkOutput("beat_argmax", longint'(bus.argmax), longint'(exp_q[0].amax));
                checkOutput("beat_in_ready", longint'(bus.in_ready), 0);
                checkOutput("beat_busy", longint'(bus.busy), 1);
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    beats_seen++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, longint'(bus.in_ready), 1);
        checkOutput({tag, "_out_valid"}, longint'(bus.out_valid), 0);
        checkOutput({tag, "_out_data"}, longint'(bus.out_data), 0);
        checkOutput({tag, "_out_index"}, longint'(bus.out_index), 0);
        checkOutput({tag, "_out_last"}, longint'(bus.out_last), 0);
        checkOutput({tag, "_argmax"}, longint'(bus.argmax), 0);
        checkOutput({tag, "_busy"}, longint'(bus.busy), 0);
    endtask

    initial begin
        vec_t zeros, peak, big, tie, q;
        int   amax;
        int   n;
        int   beats_before;

        for (int i = 0; i < NUM_CLASSES; i++) begin
            zeros[i] = 0;
            peak[i]  = 0;
            big[i]   = 0;
            tie[i]   = -20;
        end
        peak[3] = 100;
        big[3]  = 1000;
        tie[2]  = 50;
        tie[7]  = 50;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst = 1'b0;

        softmaxModel(zeros, q, amax);
        checkOutput("model_zero_q0", q[0], 25);
        checkOutput("model_zero_amax", longint'(amax), 0);
        softmaxModel(peak, q, amax);
        checkOutput("model_peak_q3", q[3], 39);
        checkOutput("model_peak_q0", q[0], 24);
        checkOutput("model_peak_amax", longint'(amax), 3);
        softmaxModel(big, q, amax);
        checkOutput("model_big_q3", q[3], 256);
        checkOutput("model_big_q5", q[5], 0);
        softmaxModel(tie, q, amax);
        checkOutput("model_tie_q2", q[2], 32);
        checkOutput("model_tie_q7", q[7], 32);
        checkOutput("model_tie_q0", q[0], 23);
        checkOutput("model_tie_amax", longint'(amax), 2);

        // All-zero frame: first beat latency and inter-beat gap.
        @(posedge clk); #1;
        applyStimulus(zeros);
        n = 0;
        while (!bus.out_valid && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("first_valid_latency", longint'(n), 20);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.out_valid && n < 500);
        checkOutput("beat_gap_low_cycles", longint'(n - 1), 9);
        waitDrain("zeros");
        checkOutput("in_ready_after_frame", longint'(bus.in_ready), 1);

        // Peak frame with backpressure on beat 4 and ignored input pulses.
        applyStimulus(peak);
        waitBeat(4);
        bus.out_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = c[0];
            bus.in_data  = W'(123);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        checkOutput("stall_out_valid", longint'(bus.out_valid), 1);
        checkOutput("stall_out_data", longint'(bus.out_data), 24);
        checkOutput("stall_out_index", longint'(bus.out_index), 4);
        checkOutput("stall_in_ready", longint'(bus.in_ready), 0);
        checkOutput("stall_busy", longint'(bus.busy), 1);
        bus.out_ready = 1'b1;
        waitDrain("peak");

        applyStimulus(big);
        waitDrain("big");

        applyStimulus(tie);
        waitDrain("tie");

        // Reset in the middle of the class-5 divide.
        applyStimulus(peak);
        waitBeat(4);
        @(posedge clk); #1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        checkOutput("pre_reset_busy", longint'(bus.busy), 1);
        rst = 1'b1;
        #1;
        checkResetValues("midrst");
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        beats_before = beats_seen;
        applyStimulus(zeros);
        waitDrain("post_reset");
        checkOutput("post_reset_beats", longint'(beats_seen - beats_before), 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
